// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - stream-fed configuration loader for the fpga fabric
//
// Purpose: accepts NUM_WORDS configuration words from a valid/ready stream,
// writes each into the fabric with a one-hot strobe, verifies a trailing XOR
// checksum word, then enables the fabric flip-flops and signals ready after
// programmable settle delays. Re-triggerable with start from DONE or ERROR.
//
// Ports:
//   clock       in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   single-cycle (re)configure request, ignored while busy
//   s_data      in   CFG_W stream word
//   s_valid     in   stream word valid
//   s_ready     out  loader accepts a beat this cycle
//   configs_in  out  CFG_W word presented to the fabric
//   configs_en  out  NUM_WORDS one-hot write strobe
//   ff_en       out  fabric flip-flop enable
//   rdy         out  configuration complete, fabric running
//   busy        out  high except in IDLE, DONE, ERROR
//   err         out  checksum mismatch, sticky until start or rst
module fpga_cfg_loader #(
  parameter int CFG_W         = 384,
  parameter int NUM_WORDS     = 267,
  parameter int SETTLE_CYCLES = 10,
  parameter int RDY_DELAY     = 10
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CFG_W-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [CFG_W-1:0]     configs_in,
  output logic [NUM_WORDS-1:0] configs_en,
  output logic                 ff_en,
  output logic                 rdy,
  output logic                 busy,
  output logic                 err
);

  localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > RDY_DELAY) ? SETTLE_CYCLES : RDY_DELAY;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, LOAD, STROBE, CHECK, EVAL, SETTLE, WAITRDY, DONE, ERROR
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CFG_W-1:0]     acc_q, acc_d;
  logic [CFG_W-1:0]     chk_q, chk_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CFG_W-1:0]     configs_in_q, configs_in_d;
  logic [NUM_WORDS-1:0] configs_en_q, configs_en_d;
  logic                 s_ready_q, s_ready_d;
  logic                 ff_en_q, ff_en_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 beat;
  logic [NUM_WORDS-1:0] one_w;

  assign beat = s_valid && s_ready_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    chk_d        = chk_q;
    cnt_d        = cnt_q;
    configs_in_d = configs_in_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      LOAD: begin
        if (beat) begin
          configs_in_d = s_data;
          acc_d        = acc_q ^ s_data;
          state_d      = STROBE;
        end
      end
      STROBE: begin
        if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
          state_d = CHECK;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      CHECK: begin
        if (beat) begin
          chk_d   = s_data;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (acc_q == chk_q) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          state_d = ERROR;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = WAITRDY;
          cnt_d   = CNT_W'(RDY_DELAY - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAITRDY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the
    // state they describe rather than lagging it by a cycle.
    one_w        = '0;
    one_w[0]     = 1'b1;
    configs_en_d = (state_d == STROBE) ? (one_w << idx_d) : '0;
    s_ready_d    = (state_d == LOAD) || (state_d == CHECK);
    ff_en_d      = (state_d == WAITRDY) || (state_d == DONE);
    rdy_d        = (state_d == DONE);
    err_d        = (state_d == ERROR);
    busy_d       = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERROR));
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      chk_q        <= '0;
      cnt_q        <= '0;
      configs_in_q <= '0;
      configs_en_q <= '0;
      s_ready_q    <= 1'b0;
      ff_en_q      <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      chk_q        <= chk_d;
      cnt_q        <= cnt_d;
      configs_in_q <= configs_in_d;
      configs_en_q <= configs_en_d;
      s_ready_q    <= s_ready_d;
      ff_en_q      <= ff_en_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign configs_in = configs_in_q;
  assign configs_en = configs_en_q;
  assign ff_en      = ff_en_q;
  assign rdy        = rdy_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - directed self-checking bench for fpga_cfg_loader
module tb_fpga_cfg_loader;

  logic       clock = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] configs_in;
  logic [3:0] configs_en;
  logic       ff_en;
  logic       rdy;
  logic       busy;
  logic       err;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] nom_w[4] = '{8'h11, 8'h22, 8'h44, 8'h88};
  logic [7:0] rec_w[4] = '{8'hAA, 8'h55, 8'h0F, 8'hF0};
  int         bp_gap[4] = '{3, 0, 5, 1};

  fpga_cfg_loader #(
    .CFG_W(8), .NUM_WORDS(4), .SETTLE_CYCLES(3), .RDY_DELAY(2)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .configs_in(configs_in), .configs_en(configs_en),
    .ff_en(ff_en), .rdy(rdy), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_cfg_en"}, configs_en, 0);
    check({tag, "_cfg_in"}, configs_in, 0);
    check({tag, "_ff_en"}, ff_en, 0);
    check({tag, "_rdy"}, rdy, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_s_ready", s_ready, 1);
    check("start_busy", busy, 1);
    check("start_err", err, 0);
    check("start_ff_en", ff_en, 0);
    check("start_rdy", rdy, 0);
  endtask

  // Delivers one word after 'gap' idle cycles; s_valid stays high with junk
  // data through the strobe cycle so an extra accepted beat would show up.
  task automatic send_word(input logic [7:0] w, input int k, input int gap);
    logic [3:0] exp_en;
    exp_en  = 4'b0001 << k;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick;
      check("gap_cfg_en", configs_en, 0);
      check("gap_s_ready", s_ready, 1);
    end
    s_data  = w;
    s_valid = 1'b1;
    tick;
    check("strobe_cfg_en", configs_en, exp_en);
    check("strobe_cfg_in", configs_in, w);
    check("strobe_s_ready", s_ready, 0);
    s_data = 8'hEE;
    tick;
    check("post_cfg_en", configs_en, 0);
    check("post_cfg_in_hold", configs_in, w);
    check("post_s_ready", s_ready, 1);
    s_valid = 1'b0;
  endtask

  task automatic send_check(input logic [7:0] c, input bit pass_exp);
    s_data  = c;
    s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    check("eval_busy", busy, 1);
    check("eval_cfg_en", configs_en, 0);
    check("eval_s_ready", s_ready, 0);
    tick;
    if (!pass_exp) begin
      check("bad_err", err, 1);
      check("bad_busy", busy, 0);
      check("bad_ff_en", ff_en, 0);
      check("bad_rdy", rdy, 0);
      repeat (3) tick;
      check("bad_err_sticky", err, 1);
      check("bad_ff_en_late", ff_en, 0);
      check("bad_rdy_late", rdy, 0);
    end else begin
      check("pass_err", err, 0);
      check("pass_ff_en_c2", ff_en, 0);
      tick;
      tick;
      check("pass_ff_en_c4", ff_en, 0);
      tick;
      check("pass_ff_en_c5", ff_en, 1);
      check("pass_rdy_c5", rdy, 0);
      tick;
      check("pass_rdy_c6", rdy, 0);
      tick;
      check("pass_rdy_c7", rdy, 1);
      check("pass_ff_en_c7", ff_en, 1);
      check("pass_busy_c7", busy, 0);
      check("pass_err_c7", err, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_data  = 8'h00;
    s_valid = 1'b0;
    repeat (3) tick;
    check_idle_outputs("reset");
    rst = 1'b0;
    tick;
    check_idle_outputs("idle");

    // nominal load
    do_start;
    for (int k = 0; k < 4; k++) send_word(nom_w[k], k, 0);
    send_check(8'hFF, 1'b1);

    // reconfigure from DONE
    start = 1'b1;
    tick;
    start = 1'b0;
    check("reconf_ff_en", ff_en, 0);
    check("reconf_rdy", rdy, 0);
    check("reconf_s_ready", s_ready, 1);
    check("reconf_busy", busy, 1);
    for (int k = 0; k < 4; k++) send_word(rec_w[k], k, 0);
    send_check(8'h00, 1'b1);

    // bad checksum
    do_start;
    for (int k = 0; k < 4; k++) send_word(nom_w[k], k, 0);
    send_check(8'hFE, 1'b0);

    // recovery from ERROR, then back-pressured load with a checksum stall
    do_start;
    for (int k = 0; k < 4; k++) send_word(nom_w[k], k, bp_gap[k]);
    for (int g = 0; g < 4; g++) begin
      tick;
      check("chk_stall_s_ready", s_ready, 1);
      check("chk_stall_busy", busy, 1);
      check("chk_stall_cfg_en", configs_en, 0);
    end
    send_check(8'hFF, 1'b1);

    // reset during STROBE of word 2
    do_start;
    send_word(nom_w[0], 0, 0);
    send_word(nom_w[1], 1, 0);
    s_data  = nom_w[2];
    s_valid = 1'b1;
    tick;
    check("rst_pre_cfg_en", configs_en, 4'b0100);
    s_valid = 1'b0;
    rst     = 1'b1;
    tick;
    rst = 1'b0;
    check_idle_outputs("mid_rst");
    tick;
    check("mid_rst_stays_idle", s_ready, 0);

    // start while busy is ignored: load continues at word 1
    do_start;
    send_word(nom_w[0], 0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_start_s_ready", s_ready, 1);
    check("busy_start_cfg_en", configs_en, 0);
    for (int k = 1; k < 4; k++) send_word(nom_w[k], k, 0);
    send_check(8'hFF, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Synthesizable, parametrised configuration loader for the `fpga` fabric.
- Accepts configuration words from a valid/ready stream and writes each one into the fabric with a one-hot `configs_en` strobe.
- Checks a trailing XOR checksum, then releases the fabric flip-flops (`ff_en`) and raises `rdy` after programmable settle delays.
- Replaces file-driven bench loading, can be re-triggered for reconfiguration, and sits between any bitstream source (bench, UART, SPI) and the `fpga` instance.

## Interface
- `CFG_W`, 384: width of one configuration word / `configs_in`.
- `NUM_WORDS`, 267: number of configuration words; width of `configs_en`. Must be ≥ 1.
- `SETTLE_CYCLES`, 10: cycles from checksum pass to `ff_en` rising. Must be ≥ 1.
- `RDY_DELAY`, 10: cycles from `ff_en` rising to `rdy` rising. Must be ≥ 1.
- `clock`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle request to (re)configure.
- `s_data`, in, `CFG_W`: stream word.
- `s_valid`, in, 1: `s_data` is valid.
- `s_ready`, out, 1: loader accepts a beat this cycle.
- `configs_in`, out, `CFG_W`: word presented to the fabric.
- `configs_en`, out, `NUM_WORDS`: one-hot write strobe; all-zero when not writing.
- `ff_en`, out, 1: fabric flip-flop enable.
- `rdy`, out, 1: configuration complete and fabric running.
- `busy`, out, 1: high in every state except IDLE, DONE and ERROR.
- `err`, out, 1: checksum mismatch; sticky until `start` or `rst`.

## Operation
- A beat transfers on a rising edge where `s_valid && s_ready`.
- All outputs are registered.
- State machine states: IDLE, LOAD, STROBE, CHECK, EVAL, SETTLE, WAITRDY, DONE, ERROR.
- IDLE
  - All outputs low.
  - `start` → LOAD; clears `idx` and the checksum accumulator.
- LOAD
  - `s_ready` = 1.
  - On a beat: `configs_in` ← `s_data`; accumulator ^= `s_data`; → STROBE.
- STROBE (exactly one cycle)
  - `configs_en` = 1 << `idx`; `s_ready` = 0.
  - If `idx` == `NUM_WORDS`-1 → CHECK; else `idx`++ and → LOAD.
- CHECK
  - `s_ready` = 1.
  - On a beat: latch the checksum word; → EVAL. This beat is not written to the fabric.
- EVAL (one cycle)
  - accumulator == checksum → SETTLE.
  - Mismatch → ERROR.
- SETTLE: count `SETTLE_CYCLES`, then `ff_en` ← 1; → WAITRDY.
- WAITRDY: count `RDY_DELAY`, then `rdy` ← 1; → DONE.
- DONE
  - `ff_en` = `rdy` = 1.
  - `start` → LOAD, with `ff_en` and `rdy` dropping to 0 in the same edge.
- ERROR
  - `err` = 1; `ff_en` = `rdy` = 0.
  - `start` clears `err` → LOAD.
- `start` is ignored while `busy` = 1.
- `configs_in` holds its last value outside STROBE.
- `configs_en` is never non-zero outside STROBE and never has more than one bit set.
- `idx` counts 0..`NUM_WORDS`-1 and never wraps past it.

## Timing
- Reset values:
  - `s_ready` = `configs_en` = `ff_en` = `rdy` = `busy` = `err` = 0.
  - `configs_in` = 0.
  - State = IDLE.
- `start` sampled at edge t: `s_ready` = 1 and `busy` = 1 from cycle t+1.
- Beat at edge a:
  - `configs_in` = word and `configs_en[idx]` = 1 during cycle a+1 only.
  - `s_ready` = 1 again in cycle a+2.
- Throughput is 2 cycles per word with `s_valid` held high. A full load with zero stall takes 2·`NUM_WORDS` + 1 cycles to the checksum beat.
- Checksum beat at edge c:
  - EVAL is cycle c+1.
  - On pass: `ff_en` = 1 from cycle c+2+`SETTLE_CYCLES`; `rdy` = 1 from `RDY_DELAY` cycles later.
  - On fail: `err` = 1 from cycle c+2.
- `s_valid` low in LOAD or CHECK: stall indefinitely; no timeout.
- `rst` mid-load:
  - All outputs at reset values on the next cycle, including `configs_en` = 0 even if reset lands during STROBE.
  - Words partially written to the fabric are not restored.

## Test plan
Parameters for all scenarios: `CFG_W`=8, `NUM_WORDS`=4, `SETTLE_CYCLES`=3, `RDY_DELAY`=2.
- **Nominal load.** Stream 0x11, 0x22, 0x44, 0x88, checksum 0xFF with `s_valid` held high → `configs_en` pulses 0001, 0010, 0100, 1000 with `configs_in` equal to the matching word. `ff_en` rises 5 cycles after the checksum edge; `rdy` rises 2 cycles later; `err` = 0.
- **Bad checksum.** Same words, checksum 0xFE → `err` = 1 at checksum edge +2; `ff_en` and `rdy` stay 0; state ERROR. Then `start` → `err` clears and `s_ready` = 1 the next cycle.
- **Back-pressure.** Random `s_valid` gaps of 0–5 cycles → identical strobe sequence, no duplicate or dropped `configs_en` pulse, and `configs_en` = 0 throughout each gap.
- **Reconfigure.** `start` in DONE → `ff_en` and `rdy` = 0 on the next cycle. A second load of 0xAA, 0x55, 0x0F, 0xF0 (checksum 0x00) completes with `rdy` = 1.
- **Reset mid-operation.** Assert `rst` during STROBE of word 2 → `configs_en` = 0 and all outputs at reset values on the next cycle. `start` pulsed while `busy` = 1 in a separate load is ignored.
